// File: rtl/csr_access_initiator_if.sv
// csr_access_initiator_if
//   Bundles the command channel, regfile strobe/exception port, debug-mode
//   controls and the response channel of the CSR access initiator.
//   slave  : the initiator (drives ready, strobes, response, debug flag)
//   master : the requester/regfile side (drives commands, exceptions, rsp_ready)
interface csr_access_initiator_if #(
   parameter int FAULT_CNT_W = 8
);
   logic                   req_valid_i;
   logic                   req_ready_o;
   logic                   req_write_i;
   logic [63:0]            req_addr_i;
   logic                   halt_req_i;
   logic                   resume_req_i;
   logic                   csr_we;
   logic                   csr_read;
   logic [63:0]            csr_addr_o;
   logic                   debug_mode_q;
   logic [63:0]            csr_exception_i_cause;
   logic                   csr_exception_i_valid;
   logic                   rsp_valid_o;
   logic                   rsp_ready_i;
   logic                   rsp_error_o;
   logic                   rsp_blocked_o;
   logic [63:0]            rsp_cause_o;
   logic [FAULT_CNT_W-1:0] fault_cnt_o;

   modport slave (
      input  req_valid_i, req_write_i, req_addr_i, halt_req_i, resume_req_i,
             csr_exception_i_cause, csr_exception_i_valid, rsp_ready_i,
      output req_ready_o, csr_we, csr_read, csr_addr_o, debug_mode_q,
             rsp_valid_o, rsp_error_o, rsp_blocked_o, rsp_cause_o, fault_cnt_o
   );

   modport master (
      output req_valid_i, req_write_i, req_addr_i, halt_req_i, resume_req_i,
             csr_exception_i_cause, csr_exception_i_valid, rsp_ready_i,
      input  req_ready_o, csr_we, csr_read, csr_addr_o, debug_mode_q,
             rsp_valid_o, rsp_error_o, rsp_blocked_o, rsp_cause_o, fault_cnt_o
   );
endinterface

// File: rtl/csr_access_initiator.sv
// csr_access_initiator
//   Requester-side sequencer for the CSR regfile port. Accepts one command at
//   a time, issues a single-cycle csr_we/csr_read strobe, samples the regfile's
//   combinational exception and returns a status response. Owns the debug-mode
//   flag and blocks debug-only CSRs (addr[11:4] == DEBUG_ADDR_HI) locally while
//   not in debug mode, independent of the regfile's own check.
// Ports
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : command / strobe / exception / response / debug signals (slave)
module csr_access_initiator #(
   parameter logic [7:0]  DEBUG_ADDR_HI = 8'h7b,
   parameter logic [63:0] ILLEGAL_INSTR = 64'd2,
   parameter int          FAULT_CNT_W   = 8
) (
   input logic                  clk_i,
   input logic                  rst_i,
   csr_access_initiator_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                 state_q, state_d;
   logic                   wr_q;
   logic [63:0]            addr_q;
   logic                   err_q, blk_q;
   logic [63:0]            cause_q;
   logic                   dbg_q;
   logic [FAULT_CNT_W-1:0] cnt_q;

   logic                   ready, we, rd, rsp_valid;
   logic [63:0]            csr_addr;
   logic                   blocked;

   // Mode only changes in IDLE, so dbg_q is stable through ISSUE.
   assign blocked = (addr_q[11:4] == DEBUG_ADDR_HI) && !dbg_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ready     = 1'b0;
      we        = 1'b0;
      rd        = 1'b0;
      csr_addr  = '0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (bus.req_valid_i) state_d = ISSUE;
         end
         ISSUE: begin
            csr_addr = addr_q;
            we       = !blocked &&  wr_q;
            rd       = !blocked && !wr_q;
            state_d  = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         err_q   <= 1'b0;
         blk_q   <= 1'b0;
         cause_q <= '0;
         dbg_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // halt has priority over resume
               if (bus.halt_req_i)        dbg_q <= 1'b1;
               else if (bus.resume_req_i) dbg_q <= 1'b0;
               if (bus.req_valid_i) begin
                  wr_q   <= bus.req_write_i;
                  addr_q <= bus.req_addr_i;
               end
            end
            ISSUE: begin
               if (blocked) begin
                  err_q   <= 1'b1;
                  blk_q   <= 1'b1;
                  cause_q <= ILLEGAL_INSTR;
               end else if (bus.csr_exception_i_valid) begin
                  err_q   <= 1'b1;
                  blk_q   <= 1'b0;
                  cause_q <= bus.csr_exception_i_cause;
               end else begin
                  err_q   <= 1'b0;
                  blk_q   <= 1'b0;
                  cause_q <= '0;
               end
            end
            RESP: begin
               if (bus.rsp_ready_i && err_q && (cnt_q != '1))
                  cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready_o   = ready;
   assign bus.csr_we        = we;
   assign bus.csr_read      = rd;
   assign bus.csr_addr_o    = csr_addr;
   assign bus.debug_mode_q  = dbg_q;
   assign bus.rsp_valid_o   = rsp_valid;
   // Payload is only meaningful with rsp_valid_o; keep it zero otherwise.
   assign bus.rsp_error_o   = rsp_valid && err_q;
   assign bus.rsp_blocked_o = rsp_valid && blk_q;
   assign bus.rsp_cause_o   = rsp_valid ? cause_q : 64'd0;
   assign bus.fault_cnt_o   = cnt_q;

endmodule

// File: tb/tb_csr_access_initiator.sv
module tb_csr_access_initiator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   csr_access_initiator_if #(.FAULT_CNT_W(8)) bus ();

   csr_access_initiator dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Regfile stand-in: exception is combinational from the strobes.
   logic        exc_en;
   logic [63:0] exc_cause;
   assign bus.csr_exception_i_valid = exc_en & (bus.csr_we | bus.csr_read);
   assign bus.csr_exception_i_cause = exc_cause;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          wr;
      logic [63:0] addr;
      bit          halt;
      bit          resume;
      bit          ev;
      logic [63:0] ec;
      int          bp;
      bit          hr;      // drive halt_req_i during RESP backpressure
      bit          e_err;
      bit          e_blk;
      logic [63:0] e_cause;
      bit          e_dbg;
      int          e_we;
      int          e_rd;
      int          e_cnt;
   } vec_t;

   // Reference model: mode flag and fault counter as plain values.
   bit m_dbg = 1'b0;
   int m_cnt = 0;

   function automatic void model(inout vec_t v);
      if (v.halt)        m_dbg = 1'b1;
      else if (v.resume) m_dbg = 1'b0;
      v.e_blk   = (v.addr[11:4] == 8'h7b) && !m_dbg;
      v.e_err   = v.e_blk || v.ev;
      v.e_cause = v.e_blk ? 64'd2 : (v.ev ? v.ec : 64'd0);
      v.e_we    = (!v.e_blk && v.wr) ? 1 : 0;
      v.e_rd    = (!v.e_blk && !v.wr) ? 1 : 0;
      v.e_dbg   = m_dbg;
      if (v.e_err && m_cnt < 255) m_cnt++;
      v.e_cnt   = m_cnt;
   endfunction

   // Entered and left at posedge+1 with the DUT in IDLE.
   task automatic txn(input vec_t v);
      int we_n, rd_n;
      chk("idle_ready", bus.req_ready_o, 1);
      bus.req_valid_i  = 1'b1;
      bus.req_write_i  = v.wr;
      bus.req_addr_i   = v.addr;
      bus.halt_req_i   = v.halt;
      bus.resume_req_i = v.resume;
      exc_en    = v.ev;
      exc_cause = v.ec;
      @(posedge clk); #1;
      bus.req_valid_i  = 1'b0;
      bus.halt_req_i   = 1'b0;
      bus.resume_req_i = 1'b0;
      bus.req_write_i  = 1'($urandom);
      bus.req_addr_i   = {$urandom, $urandom};
      we_n = int'(bus.csr_we);
      rd_n = int'(bus.csr_read);
      chk("issue_addr", bus.csr_addr_o, v.addr);
      chk("issue_ready", bus.req_ready_o, 0);
      chk("issue_dbg", bus.debug_mode_q, v.e_dbg);
      chk("issue_rsp_valid", bus.rsp_valid_o, 0);
      @(posedge clk); #1;
      for (int i = 0; i <= v.bp; i++) begin
         chk("rsp_valid", bus.rsp_valid_o, 1);
         chk("rsp_error", bus.rsp_error_o, v.e_err);
         chk("rsp_blocked", bus.rsp_blocked_o, v.e_blk);
         chk("rsp_cause", bus.rsp_cause_o, v.e_cause);
         chk("resp_addr_zero", bus.csr_addr_o, 0);
         chk("resp_dbg", bus.debug_mode_q, v.e_dbg);
         we_n += int'(bus.csr_we);
         rd_n += int'(bus.csr_read);
         if (i < v.bp) begin
            bus.halt_req_i = v.hr;
            @(posedge clk); #1;
         end
      end
      bus.halt_req_i  = 1'b0;
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b0;
      chk("post_rsp_valid", bus.rsp_valid_o, 0);
      chk("post_ready", bus.req_ready_o, 1);
      chk("we_count", we_n, v.e_we);
      chk("rd_count", rd_n, v.e_rd);
      chk("post_dbg", bus.debug_mode_q, v.e_dbg);
      chk("fault_cnt", bus.fault_cnt_o, v.e_cnt);
   endtask

   vec_t tbl[9];
   vec_t v;

   initial begin
      //            wr addr      h r ev ec                      bp hr err blk cause                  dbg we rd cnt
      tbl[0] = '{0, 'h300,   0,0,0, 'hdead,                  0, 0, 0,0, 0,                     0, 0,1, 0};
      tbl[1] = '{1, 'h7b0,   0,0,0, 'hdead,                  0, 0, 1,1, 2,                     0, 0,0, 1};
      tbl[2] = '{0, 'h7b1,   1,0,0, 0,                       0, 0, 0,0, 0,                     1, 0,1, 1};
      tbl[3] = '{1, 'h300,   0,0,1, 2,                       1, 0, 1,0, 2,                     1, 1,0, 2};
      tbl[4] = '{0, 'h7b2,   0,1,0, 'hbeef,                  0, 0, 1,1, 2,                     0, 0,0, 3};
      tbl[5] = '{0, 'h7b3,   1,1,0, 0,                       0, 0, 0,0, 0,                     1, 0,1, 3};
      tbl[6] = '{1, 'h7bf,   0,1,0, 0,                       3, 1, 1,1, 2,                     0, 0,0, 4};
      tbl[7] = '{0, 'h17b0,  0,0,0, 0,                       2, 0, 1,1, 2,                     0, 0,0, 5};
      tbl[8] = '{1, 'h7c0,   0,0,1, 'h123456789abcdef0,      0, 0, 1,0, 'h123456789abcdef0,    0, 1,0, 6};

      bus.req_valid_i  = 1'b0;
      bus.req_write_i  = 1'b0;
      bus.req_addr_i   = '0;
      bus.halt_req_i   = 1'b0;
      bus.resume_req_i = 1'b0;
      bus.rsp_ready_i  = 1'b0;
      exc_en    = 1'b0;
      exc_cause = '0;

      // Reset state
      #1;
      chk("rst_we", bus.csr_we, 0);
      chk("rst_read", bus.csr_read, 0);
      chk("rst_addr", bus.csr_addr_o, 0);
      chk("rst_dbg", bus.debug_mode_q, 0);
      chk("rst_rsp_valid", bus.rsp_valid_o, 0);
      chk("rst_cause", bus.rsp_cause_o, 0);
      chk("rst_cnt", bus.fault_cnt_o, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready", bus.req_ready_o, 1);

      // Directed table
      for (int i = 0; i < 9; i++) begin
         v = tbl[i];
         model(v);   // advance model state alongside the table
         txn(tbl[i]);
      end

      // Halt pulse in IDLE, debug read, then resume pulse
      bus.halt_req_i = 1'b1;
      @(posedge clk); #1;
      bus.halt_req_i = 1'b0;
      chk("halt_dbg", bus.debug_mode_q, 1);
      m_dbg = 1'b1;
      v = '{0, 'h7b1, 0,0,0, 0, 0,0, 0,0,0,0,0,0,0};
      model(v);
      chk("halt_model_rd", v.e_rd, 1);
      txn(v);
      bus.resume_req_i = 1'b1;
      @(posedge clk); #1;
      bus.resume_req_i = 1'b0;
      chk("resume_dbg", bus.debug_mode_q, 0);
      m_dbg = 1'b0;

      // Reset during ISSUE, with debug mode on and a nonzero counter
      bus.halt_req_i = 1'b1;
      @(posedge clk); #1;
      bus.halt_req_i = 1'b0;
      bus.req_valid_i = 1'b1;
      bus.req_write_i = 1'b0;
      bus.req_addr_i  = 64'h300;
      exc_en = 1'b0;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      chk("pre_rst_read", bus.csr_read, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_read", bus.csr_read, 0);
      chk("arst_addr", bus.csr_addr_o, 0);
      chk("arst_dbg", bus.debug_mode_q, 0);
      chk("arst_cnt", bus.fault_cnt_o, 0);
      chk("arst_rsp_valid", bus.rsp_valid_o, 0);
      @(negedge clk); rst = 1'b0;
      m_dbg = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("dropped_no_rsp", bus.rsp_valid_o, 0);
         chk("dropped_ready", bus.req_ready_o, 1);
      end
      v = '{0, 'h300, 0,0,0, 0, 0,0, 0,0,0,0,0,0,0};
      model(v);
      txn(v);

      // Randomized against the model
      for (int n = 0; n < 40; n++) begin
         logic [63:0] a;
         int sel;
         a   = {$urandom, $urandom};
         sel = int'($urandom_range(0, 2));
         if (sel == 0)      a[11:4] = 8'h7b;
         else if (sel == 1) a = 64'h300;
         v = '{0, 0, 0,0,0, 0, 0,0, 0,0,0,0,0,0,0};
         v.wr     = 1'($urandom);
         v.addr   = a;
         v.halt   = ($urandom_range(0, 3) == 0);
         v.resume = ($urandom_range(0, 3) == 0);
         v.ev     = ($urandom_range(0, 2) == 0);
         v.ec     = {$urandom, $urandom};
         v.bp     = int'($urandom_range(0, 3));
         v.hr     = 1'($urandom);
         model(v);
         txn(v);
      end

      // Saturation: enough blocked accesses to pass 255
      for (int n = 0; n < 260; n++) begin
         v = '{0, 'h7b0, 0,1,0, 0, 0,0, 0,0,0,0,0,0,0};
         v.wr = 1'($urandom);
         model(v);
         txn(v);
      end
      chk("sat_cnt", bus.fault_cnt_o, 255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
